// File: rtl/scpad_rsp_unpacker_if.sv
// rtl/scpad_rsp_unpacker_if.sv - descriptor, response-beat and output-row bundle for scpad_rsp_unpacker
//
// Ports:
//   cmd_*  : tile-read descriptor (rows_m1, cols_m1, src, id) with valid/ready
//   rsp_*  : raw bank-order beat plus per-lane source-lane shift mask with valid/ready
//   out_*  : row-major row with lane mask, row index, last flag, src and id with valid/ready
//   busy   : descriptors queued or rows buffered
// master = producer of descriptors/beats and consumer of rows; slave = the unpacker.

interface scpad_rsp_unpacker_if #(
    parameter int NUM_COLS      = 32,
    parameter int ELEM_BITS     = 16,
    parameter int MAX_TILE_SIZE = 32,
    parameter int DRAM_ID_WIDTH = 6
);
    localparam int COL_IDX_WIDTH = $clog2(NUM_COLS);
    localparam int MAX_DIM_WIDTH = $clog2(MAX_TILE_SIZE);

    logic                              cmd_valid;
    logic                              cmd_ready;
    logic [MAX_DIM_WIDTH-1:0]          cmd_rows_m1;
    logic [MAX_DIM_WIDTH-1:0]          cmd_cols_m1;
    logic                              cmd_src;
    logic [DRAM_ID_WIDTH-1:0]          cmd_id;

    logic                              rsp_valid;
    logic                              rsp_ready;
    logic [NUM_COLS*ELEM_BITS-1:0]     rsp_data;
    logic [NUM_COLS*COL_IDX_WIDTH-1:0] rsp_shift;

    logic                              out_valid;
    logic                              out_ready;
    logic [NUM_COLS*ELEM_BITS-1:0]     out_data;
    logic [NUM_COLS-1:0]               out_mask;
    logic [MAX_DIM_WIDTH-1:0]          out_row;
    logic                              out_last;
    logic                              out_src;
    logic [DRAM_ID_WIDTH-1:0]          out_id;

    logic                              busy;

    modport master (
        output cmd_valid, cmd_rows_m1, cmd_cols_m1, cmd_src, cmd_id,
        input  cmd_ready,
        output rsp_valid, rsp_data, rsp_shift,
        input  rsp_ready,
        input  out_valid, out_data, out_mask, out_row, out_last, out_src, out_id,
        output out_ready,
        input  busy
    );

    modport slave (
        input  cmd_valid, cmd_rows_m1, cmd_cols_m1, cmd_src, cmd_id,
        output cmd_ready,
        input  rsp_valid, rsp_data, rsp_shift,
        output rsp_ready,
        output out_valid, out_data, out_mask, out_row, out_last, out_src, out_id,
        input  out_ready,
        output busy
    );
endinterface

// File: rtl/scpad_rsp_unpacker.sv
// rtl/scpad_rsp_unpacker.sv - un-shuffles scratchpad read-response beats into tagged row-major rows
//
// Ports:
//   CLK : clock, all state on rising edge
//   RST : asynchronous active-high reset
//   bus : scpad_rsp_unpacker_if.slave (cmd_*, rsp_*, out_*, busy)
// Parameters must match those of the connected interface instance.

module scpad_rsp_unpacker #(
    parameter int NUM_COLS      = 32,
    parameter int ELEM_BITS     = 16,
    parameter int MAX_TILE_SIZE = 32,
    parameter int DRAM_ID_WIDTH = 6,
    parameter int CMD_DEPTH     = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    scpad_rsp_unpacker_if.slave  bus
);
    localparam int COL_IDX_WIDTH = $clog2(NUM_COLS);
    localparam int MAX_DIM_WIDTH = $clog2(MAX_TILE_SIZE);
    localparam int DATA_W        = NUM_COLS * ELEM_BITS;
    localparam int CMD_PTR_W     = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CMD_CNT_W     = $clog2(CMD_DEPTH + 1);

    // descriptor queue
    logic [MAX_DIM_WIDTH-1:0] cq_rows [CMD_DEPTH];
    logic [MAX_DIM_WIDTH-1:0] cq_cols [CMD_DEPTH];
    logic                     cq_src  [CMD_DEPTH];
    logic [DRAM_ID_WIDTH-1:0] cq_id   [CMD_DEPTH];
    logic [CMD_PTR_W-1:0]     cq_wp, cq_rp;
    logic [CMD_CNT_W-1:0]     cq_cnt;

    // two-entry output row FIFO
    logic [DATA_W-1:0]        of_data [2];
    logic [NUM_COLS-1:0]      of_mask [2];
    logic [MAX_DIM_WIDTH-1:0] of_row  [2];
    logic                     of_last [2];
    logic                     of_src  [2];
    logic [DRAM_ID_WIDTH-1:0] of_id   [2];
    logic                     of_wp, of_rp;
    logic [1:0]               of_cnt;

    logic [MAX_DIM_WIDTH-1:0] row_q;

    logic                     cmd_full, cmd_push, cmd_pop;
    logic                     rsp_fire, out_fire, beat_last;
    logic [MAX_DIM_WIDTH-1:0] head_rows, head_cols;
    logic [DATA_W-1:0]        lane_data;
    logic [NUM_COLS-1:0]      lane_mask;

    function automatic logic [CMD_PTR_W-1:0] cq_next(input logic [CMD_PTR_W-1:0] p);
        return (p == CMD_PTR_W'(CMD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_rows = cq_rows[cq_rp];
    assign head_cols = cq_cols[cq_rp];

    // a pop in the same cycle does not free a slot for a push: ready is purely !full
    assign cmd_full      = (cq_cnt == CMD_CNT_W'(CMD_DEPTH));
    assign bus.cmd_ready = !cmd_full;
    assign cmd_push      = bus.cmd_valid && !cmd_full;

    // beat acceptance looks only at registered occupancy, never at out_ready
    assign bus.rsp_ready = (cq_cnt != '0) && (of_cnt < 2'd2);
    assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;
    assign beat_last     = (row_q == head_rows);
    assign cmd_pop       = rsp_fire && beat_last;

    assign out_fire      = (of_cnt != 2'd0) && bus.out_ready;

    // output lane i takes source lane rsp_shift[i]; lanes past the tile width are zeroed
    always_comb begin
        lane_data = '0;
        lane_mask = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (i <= int'(head_cols)) begin
                lane_mask[i] = 1'b1;
                lane_data[i*ELEM_BITS +: ELEM_BITS] =
                    bus.rsp_data[int'(bus.rsp_shift[i*COL_IDX_WIDTH +: COL_IDX_WIDTH])*ELEM_BITS +: ELEM_BITS];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < CMD_DEPTH; i++) begin
                cq_rows[i] <= '0;
                cq_cols[i] <= '0;
                cq_src[i]  <= 1'b0;
                cq_id[i]   <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                of_data[i] <= '0;
                of_mask[i] <= '0;
                of_row[i]  <= '0;
                of_last[i] <= 1'b0;
                of_src[i]  <= 1'b0;
                of_id[i]   <= '0;
            end
            cq_wp  <= '0;
            cq_rp  <= '0;
            cq_cnt <= '0;
            of_wp  <= 1'b0;
            of_rp  <= 1'b0;
            of_cnt <= 2'd0;
            row_q  <= '0;
        end else begin
            if (cmd_push) begin
                cq_rows[cq_wp] <= bus.cmd_rows_m1;
                cq_cols[cq_wp] <= bus.cmd_cols_m1;
                cq_src[cq_wp]  <= bus.cmd_src;
                cq_id[cq_wp]   <= bus.cmd_id;
                cq_wp          <= cq_next(cq_wp);
            end
            if (cmd_pop) begin
                cq_rp <= cq_next(cq_rp);
            end
            case ({cmd_push, cmd_pop})
                2'b10:   cq_cnt <= cq_cnt + 1'b1;
                2'b01:   cq_cnt <= cq_cnt - 1'b1;
                default: ;
            endcase

            if (rsp_fire) begin
                of_data[of_wp] <= lane_data;
                of_mask[of_wp] <= lane_mask;
                of_row[of_wp]  <= row_q;
                of_last[of_wp] <= beat_last;
                of_src[of_wp]  <= cq_src[cq_rp];
                of_id[of_wp]   <= cq_id[cq_rp];
                of_wp          <= ~of_wp;
                row_q          <= beat_last ? '0 : row_q + 1'b1;
            end
            if (out_fire) begin
                of_rp <= ~of_rp;
            end
            case ({rsp_fire, out_fire})
                2'b10:   of_cnt <= of_cnt + 2'd1;
                2'b01:   of_cnt <= of_cnt - 2'd1;
                default: ;
            endcase
        end
    end

    assign bus.out_valid = (of_cnt != 2'd0);
    assign bus.out_data  = of_data[of_rp];
    assign bus.out_mask  = of_mask[of_rp];
    assign bus.out_row   = of_row[of_rp];
    assign bus.out_last  = of_last[of_rp];
    assign bus.out_src   = of_src[of_rp];
    assign bus.out_id    = of_id[of_rp];
    assign bus.busy      = (cq_cnt != '0) || (of_cnt != 2'd0);

endmodule
